clock_switch_controller: RTL and testbench



---
 rtl/clock_switch_controller.sv | 169 ++++++++++++++++
 tb/tb_clock_switch_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_switch_controller.sv
// Break-before-make sequencer for a two-input clock mux: gates off, flips select, settles, gates on.
// Define CLOCK_SWITCH_LOCK_CHECK_EN to wait for target-clock lock (with timeout abort) before settling.
module clock_switch_controller #(
    parameter int GATE_WAIT    = 4,
    parameter int SETTLE_WAIT  = 4,
    parameter int LOCK_TIMEOUT = 256,
    parameter int CNT_WIDTH    = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_select,
    output logic       req_ready,
    output logic       mux_select,
    output logic       gate_en0,
    output logic       gate_en1,
    output logic       busy,
`ifdef CLOCK_SWITCH_LOCK_CHECK_EN
    input  logic [1:0] clk_locked,
    output logic       error,
`endif
    output logic       done
);

    localparam int MAX_LOAD = (GATE_WAIT > SETTLE_WAIT)
                            ? ((GATE_WAIT > LOCK_TIMEOUT) ? GATE_WAIT : LOCK_TIMEOUT)
                            : ((SETTLE_WAIT > LOCK_TIMEOUT) ? SETTLE_WAIT : LOCK_TIMEOUT);

    if (GATE_WAIT < 1 || SETTLE_WAIT < 1 || LOCK_TIMEOUT < 1 ||
        64'(MAX_LOAD) >= (64'd1 << CNT_WIDTH)) begin : g_param_check
        $error("clock_switch_controller: wait parameters must be >= 1 and fit in CNT_WIDTH bits");
    end

    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] GATE_LOAD   = CNT_WIDTH'(GATE_WAIT);
    localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(SETTLE_WAIT);
`ifdef CLOCK_SWITCH_LOCK_CHECK_EN
    localparam logic [CNT_WIDTH-1:0] LOCK_LOAD   = CNT_WIDTH'(LOCK_TIMEOUT);

    typedef enum logic [2:0] {IDLE, GATE_OFF, LOCK_WAIT, SETTLE, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, GATE_OFF, SETTLE, DONE} state_t;
`endif

    state_t               state, state_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;
    logic                 target, target_n;
    logic                 mux_n, gate0_n, gate1_n, ready_n, busy_n, done_n;
`ifdef CLOCK_SWITCH_LOCK_CHECK_EN
    logic                 error_n;
    logic                 lock_ok;

    // Select 1 routes input0, so its lock status lives in bit 0.
    assign lock_ok = target ? clk_locked[0] : clk_locked[1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            target     <= 1'b1;
            mux_select <= 1'b1;
            gate_en0   <= 1'b1;
            gate_en1   <= 1'b0;
            req_ready  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef CLOCK_SWITCH_LOCK_CHECK_EN
            error      <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            target     <= target_n;
            mux_select <= mux_n;
            gate_en0   <= gate0_n;
            gate_en1   <= gate1_n;
            req_ready  <= ready_n;
            busy       <= busy_n;
            done       <= done_n;
`ifdef CLOCK_SWITCH_LOCK_CHECK_EN
            error      <= error_n;
`endif
        end
    end

    // Every output is computed for the next state so all of them come straight from flops.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        target_n = target;
        mux_n    = mux_select;
        gate0_n  = gate_en0;
        gate1_n  = gate_en1;
        done_n   = 1'b0;
`ifdef CLOCK_SWITCH_LOCK_CHECK_EN
        error_n  = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    if (req_select == mux_select) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        target_n = req_select;
                        gate0_n  = 1'b0;
                        gate1_n  = 1'b0;
                        cnt_n    = GATE_LOAD;
                        state_n  = GATE_OFF;
                    end
                end
            end
            GATE_OFF: begin
                if (cnt == CNT_ONE) begin
`ifdef CLOCK_SWITCH_LOCK_CHECK_EN
                    state_n = LOCK_WAIT;
                    cnt_n   = LOCK_LOAD;
`else
                    state_n = SETTLE;
                    cnt_n   = SETTLE_LOAD;
                    mux_n   = target;
`endif
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
`ifdef CLOCK_SWITCH_LOCK_CHECK_EN
            LOCK_WAIT: begin
                if (lock_ok) begin
                    state_n = SETTLE;
                    cnt_n   = SETTLE_LOAD;
                    mux_n   = target;
                end else if (cnt == CNT_ONE) begin
                    // Abort keeps the old select and reopens its gate.
                    state_n = DONE;
                    done_n  = 1'b1;
                    error_n = 1'b1;
                    gate0_n = mux_select;
                    gate1_n = ~mux_select;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
`endif
            SETTLE: begin
                if (cnt == CNT_ONE) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    gate0_n = mux_select;
                    gate1_n = ~mux_select;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        ready_n = (state_n == IDLE);
        busy_n  = (state_n != IDLE);
    end

endmodule

// File: tb/tb_clock_switch_controller.sv
// Self-checking bench for clock_switch_controller: timeline expectations are queued at each
// handshake and compared cycle by cycle; gate/select safety is checked every cycle.
module tb_clock_switch_controller;

    localparam int GW = 4;
    localparam int SW = 4;
    localparam int LT = 8;
`ifdef CLOCK_SWITCH_LOCK_CHECK_EN
    localparam int LW = 1;
`else
    localparam int LW = 0;
`endif
    localparam int NO_LIMIT = 1000;

    logic clk        = 1'b0;
    logic rst        = 1'b1;
    logic req_valid  = 1'b0;
    logic req_select = 1'b1;
    logic req_ready, mux_select, gate_en0, gate_en1, busy, done;
`ifdef CLOCK_SWITCH_LOCK_CHECK_EN
    logic [1:0] clk_locked = 2'b11;
    logic       error;
`endif

    typedef struct {
        int         cyc;
        logic [6:0] vec;
        string      tag;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e_mon;
    int         cyc        = 0;
    int         n_checks   = 0;
    int         n_fail     = 0;
    logic       mon_en     = 1'b0;
    logic       prev_mux   = 1'b1;
    logic [1:0] prev_gates = 2'b10;
    logic       rst_q      = 1'b1;
    logic       model_mux  = 1'b1;
    int         t_hs;

    clock_switch_controller #(
        .GATE_WAIT    (GW),
        .SETTLE_WAIT  (SW),
        .LOCK_TIMEOUT (LT),
        .CNT_WIDTH    (9)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_select (req_select),
        .req_ready  (req_ready),
        .mux_select (mux_select),
        .gate_en0   (gate_en0),
        .gate_en1   (gate_en1),
        .busy       (busy),
`ifdef CLOCK_SWITCH_LOCK_CHECK_EN
        .clk_locked (clk_locked),
        .error      (error),
`endif
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Vector layout: {error, req_ready, busy, done, mux_select, gate_en0, gate_en1}
    function automatic logic [6:0] mk(input logic err, input logic rdy, input logic bsy,
                                      input logic dn, input logic m, input logic g0, input logic g1);
        return {err, rdy, bsy, dn, m, g0, g1};
    endfunction

    function automatic logic [6:0] observed();
        logic err;
`ifdef CLOCK_SWITCH_LOCK_CHECK_EN
        err = error;
`else
        err = 1'b0;
`endif
        return {err, req_ready, busy, done, mux_select, gate_en0, gate_en1};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: observed 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic pushExp(input int c, input logic [6:0] vec, input string tag);
        exp_t e;
        e.cyc = c;
        e.vec = vec;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic pushAt(input int t, input int k, input int limit, input logic [6:0] vec, input string tag);
        if (k <= limit) pushExp(t + k, vec, tag);
    endtask

    // Expected per-cycle outputs after a handshake in cycle t.
    task automatic pushSwitch(input int t, input logic old_m, input logic new_m, input int lock_cycles,
                              input bit abort, input int limit);
        int k;
        k = 1;
        if (old_m == new_m) begin
            pushAt(t, 1, limit, mk(0, 0, 1, 1, old_m, old_m, ~old_m), "null_done");
            pushAt(t, 2, limit, mk(0, 1, 0, 0, old_m, old_m, ~old_m), "null_idle");
            return;
        end
        for (int i = 0; i < GW; i++) begin
            pushAt(t, k, limit, mk(0, 0, 1, 0, old_m, 0, 0), "gate_off");
            k++;
        end
        for (int i = 0; i < lock_cycles; i++) begin
            pushAt(t, k, limit, mk(0, 0, 1, 0, old_m, 0, 0), "lock_wait");
            k++;
        end
        if (abort) begin
            pushAt(t, k,     limit, mk(1, 0, 1, 1, old_m, old_m, ~old_m), "abort_done");
            pushAt(t, k + 1, limit, mk(0, 1, 0, 0, old_m, old_m, ~old_m), "abort_idle");
            return;
        end
        for (int i = 0; i < SW; i++) begin
            pushAt(t, k, limit, mk(0, 0, 1, 0, new_m, 0, 0), "settle");
            k++;
        end
        pushAt(t, k,     limit, mk(0, 0, 1, 1, new_m, new_m, ~new_m), "switch_done");
        pushAt(t, k + 1, limit, mk(0, 1, 0, 0, new_m, new_m, ~new_m), "switch_idle");
    endtask

    task automatic applyStimulus(input logic sel, input bit spam, input int lock_cycles,
                                 input bit abort, input int limit, output int t);
        bit got;
        got = 0;
        t   = -1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (req_ready === 1'b1) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_select = sel;
        t = cyc;
        pushSwitch(t, model_mux, sel, lock_cycles, abort, limit);
        if (!abort) model_mux = sel;
        @(posedge clk);
        #1;
        if (spam && sel != model_mux ^ 1'b0) begin
        end
        if (spam) begin
            for (int i = 0; i < GW + lock_cycles + SW + 1; i++) begin
                req_valid  = 1'b1;
                req_select = ~req_select;
                @(posedge clk);
                #1;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    // Scoreboard compare plus per-cycle gate safety.
    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e_mon = exp_q.pop_front();
                checkOutput(e_mon.tag, 32'(observed()), 32'(e_mon.vec));
            end
            checkOutput("one_gate", 32'(gate_en0 & gate_en1), 32'd0);
            if (mux_select !== prev_mux && !rst_q)
                checkOutput("sel_change_gates", 32'({prev_gates, gate_en0, gate_en1}), 32'd0);
            prev_mux   = mux_select;
            prev_gates = {gate_en0, gate_en1};
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout at cycle %0d: observed running, expected finished", cyc);
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        pushExp(cyc, mk(0, 0, 0, 0, 1, 1, 0), "reset_hold");
        rst = 1'b0;
        pushExp(cyc + 1, mk(0, 1, 0, 0, 1, 1, 0), "reset_release");
        waitDrain();

        applyStimulus(1'b0, 0, LW, 0, NO_LIMIT, t_hs);
        waitDrain();
        applyStimulus(1'b0, 0, LW, 0, NO_LIMIT, t_hs);
        waitDrain();
        applyStimulus(1'b1, 1, LW, 0, NO_LIMIT, t_hs);
        waitDrain();
        applyStimulus(1'b1, 0, LW, 0, NO_LIMIT, t_hs);
        waitDrain();

        // Reset lands in cycle T+6 of a switch from select 1 to 0.
        applyStimulus(1'b0, 0, LW, 0, 6, t_hs);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        pushExp(cyc + 1, mk(0, 0, 0, 0, 1, 1, 0), "midreset_hold");
        @(posedge clk);
        #1;
        rst = 1'b0;
        pushExp(cyc + 1, mk(0, 1, 0, 0, 1, 1, 0), "midreset_release");
        model_mux = 1'b1;
        waitDrain();

        applyStimulus(1'b0, 0, LW, 0, NO_LIMIT, t_hs);
        waitDrain();
        applyStimulus(1'b1, 0, LW, 0, NO_LIMIT, t_hs);
        waitDrain();

`ifdef CLOCK_SWITCH_LOCK_CHECK_EN
        clk_locked = 2'b00;
        applyStimulus(1'b0, 0, LT, 1, NO_LIMIT, t_hs);
        waitDrain();

        applyStimulus(1'b0, 0, 3, 0, NO_LIMIT, t_hs);
        repeat (GW + 2) @(posedge clk);
        #1;
        clk_locked = 2'b10;
        waitDrain();

        clk_locked = 2'b11;
        applyStimulus(1'b1, 0, LW, 0, NO_LIMIT, t_hs);
        waitDrain();
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
